// File: rtl/forwarding_unit_if.sv
// forwarding_unit_if: ID-stage operand/destination information flowing into the
// forwarding unit, and the registered operand selects, stall request and stall
// counter flowing back out.
interface forwarding_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  stall_ext;
  logic                  flush;
  logic [REG_ADDR_W-1:0] id_src_top;
  logic [REG_ADDR_W-1:0] id_src_bot;
  logic                  id_src_top_en;
  logic                  id_src_bot_en;
  logic [REG_ADDR_W-1:0] id_dst_top;
  logic [REG_ADDR_W-1:0] id_dst_bot;
  logic                  id_dst_top_we;
  logic                  id_dst_bot_we;
  logic                  id_is_load;
  logic [4:0]            alu_input_sel_top;
  logic [4:0]            alu_input_sel_bot;
  logic                  hazard_stall;
  logic [CNT_W-1:0]      hazard_count;

  // Pipeline side: drives the ID fields, observes selects and stall.
  modport master (
    output stall_ext, flush,
    output id_src_top, id_src_bot, id_src_top_en, id_src_bot_en,
    output id_dst_top, id_dst_bot, id_dst_top_we, id_dst_bot_we, id_is_load,
    input  alu_input_sel_top, alu_input_sel_bot, hazard_stall, hazard_count
  );

  // Forwarding unit side.
  modport slave (
    input  stall_ext, flush,
    input  id_src_top, id_src_bot, id_src_top_en, id_src_bot_en,
    input  id_dst_top, id_dst_bot, id_dst_top_we, id_dst_bot_we, id_is_load,
    output alu_input_sel_top, alu_input_sel_bot, hazard_stall, hazard_count
  );
endinterface

// File: rtl/forwarding_unit.sv
// forwarding_unit: keeps shadow copies of the destinations of the instructions
// in EX and MEM, produces registered one-hot ALU operand selects for the next
// EX cycle, and requests a one-cycle bubble on a load-use dependency.
module forwarding_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  forwarding_unit_if.slave bus
);

  localparam logic [4:0] SEL_REG      = 5'b00001;
  localparam logic [4:0] SEL_EXMEM_T  = 5'b00010;
  localparam logic [4:0] SEL_EXMEM_B  = 5'b00100;
  localparam logic [4:0] SEL_MEMWB_T  = 5'b01000;
  localparam logic [4:0] SEL_MEMWB_B  = 5'b10000;

  typedef enum logic {IDLE, BUBBLE} state_t;

  state_t                state_q, state_d;
  logic [REG_ADDR_W-1:0] exDstTop_q, exDstTop_d;
  logic [REG_ADDR_W-1:0] exDstBot_q, exDstBot_d;
  logic                  exWeTop_q, exWeTop_d;
  logic                  exWeBot_q, exWeBot_d;
  logic                  exIsLoad_q, exIsLoad_d;
  logic [REG_ADDR_W-1:0] memDstTop_q, memDstTop_d;
  logic [REG_ADDR_W-1:0] memDstBot_q, memDstBot_d;
  logic                  memWeTop_q, memWeTop_d;
  logic                  memWeBot_q, memWeBot_d;
  logic [4:0]            selTop_q, selTop_d;
  logic [4:0]            selBot_q, selBot_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  hazardStall;

  // Raw address matches of each ID source against each shadow destination.
  logic topExT, topExB, topMemT, topMemB;
  logic botExT, botExB, botMemT, botMemB;
  logic loadHit, hazardReq;

  assign topExT  = bus.id_src_top_en && exWeTop_q  && (exDstTop_q  == bus.id_src_top);
  assign topExB  = bus.id_src_top_en && exWeBot_q  && (exDstBot_q  == bus.id_src_top);
  assign topMemT = bus.id_src_top_en && memWeTop_q && (memDstTop_q == bus.id_src_top);
  assign topMemB = bus.id_src_top_en && memWeBot_q && (memDstBot_q == bus.id_src_top);
  assign botExT  = bus.id_src_bot_en && exWeTop_q  && (exDstTop_q  == bus.id_src_bot);
  assign botExB  = bus.id_src_bot_en && exWeBot_q  && (exDstBot_q  == bus.id_src_bot);
  assign botMemT = bus.id_src_bot_en && memWeTop_q && (memDstTop_q == bus.id_src_bot);
  assign botMemB = bus.id_src_bot_en && memWeBot_q && (memDstBot_q == bus.id_src_bot);

  // A load in EX cannot forward from EX/MEM, so any dependency on it is a hazard.
  assign loadHit   = exIsLoad_q && (topExT || topExB || botExT || botExB);
  assign hazardReq = (state_q == IDLE) && loadHit && !bus.stall_ext && !bus.flush;

  // Newest producer wins; within a stage the top destination beats the bottom.
  function automatic logic [4:0] pickSel(input logic exT, input logic exB,
                                         input logic memT, input logic memB);
    if (exT)       return SEL_EXMEM_T;
    else if (exB)  return SEL_EXMEM_B;
    else if (memT) return SEL_MEMWB_T;
    else if (memB) return SEL_MEMWB_B;
    else           return SEL_REG;
  endfunction

  // Next-state for FSM, shadows, selects and counter; everything holds on stall_ext.
  always_comb begin
    state_d     = state_q;
    exDstTop_d  = exDstTop_q;
    exDstBot_d  = exDstBot_q;
    exWeTop_d   = exWeTop_q;
    exWeBot_d   = exWeBot_q;
    exIsLoad_d  = exIsLoad_q;
    memDstTop_d = memDstTop_q;
    memDstBot_d = memDstBot_q;
    memWeTop_d  = memWeTop_q;
    memWeBot_d  = memWeBot_q;
    selTop_d    = selTop_q;
    selBot_d    = selBot_q;
    count_d     = count_q;
    hazardStall = 1'b0;
    if (!bus.stall_ext) begin
      memDstTop_d = exDstTop_q;
      memDstBot_d = exDstBot_q;
      memWeTop_d  = exWeTop_q;
      memWeBot_d  = exWeBot_q;
      if (bus.flush || hazardReq) begin
        exDstTop_d = '0;
        exDstBot_d = '0;
        exWeTop_d  = 1'b0;
        exWeBot_d  = 1'b0;
        exIsLoad_d = 1'b0;
        selTop_d   = SEL_REG;
        selBot_d   = SEL_REG;
      end else begin
        exDstTop_d = bus.id_dst_top;
        exDstBot_d = bus.id_dst_bot;
        exWeTop_d  = bus.id_dst_top_we;
        exWeBot_d  = bus.id_dst_bot_we;
        exIsLoad_d = bus.id_is_load;
        selTop_d   = pickSel(topExT && !exIsLoad_q, topExB && !exIsLoad_q, topMemT, topMemB);
        selBot_d   = pickSel(botExT && !exIsLoad_q, botExB && !exIsLoad_q, botMemT, botMemB);
      end
      case (state_q)
        IDLE: begin
          if (hazardReq) begin
            hazardStall = 1'b1;
            state_d     = BUBBLE;
            if (~&count_q) count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        BUBBLE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register; reset discards any pending bubble and clears the shadows.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      exDstTop_q  <= '0;
      exDstBot_q  <= '0;
      exWeTop_q   <= 1'b0;
      exWeBot_q   <= 1'b0;
      exIsLoad_q  <= 1'b0;
      memDstTop_q <= '0;
      memDstBot_q <= '0;
      memWeTop_q  <= 1'b0;
      memWeBot_q  <= 1'b0;
      selTop_q    <= SEL_REG;
      selBot_q    <= SEL_REG;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      exDstTop_q  <= exDstTop_d;
      exDstBot_q  <= exDstBot_d;
      exWeTop_q   <= exWeTop_d;
      exWeBot_q   <= exWeBot_d;
      exIsLoad_q  <= exIsLoad_d;
      memDstTop_q <= memDstTop_d;
      memDstBot_q <= memDstBot_d;
      memWeTop_q  <= memWeTop_d;
      memWeBot_q  <= memWeBot_d;
      selTop_q    <= selTop_d;
      selBot_q    <= selBot_d;
      count_q     <= count_d;
    end
  end

  assign bus.alu_input_sel_top = selTop_q;
  assign bus.alu_input_sel_bot = selBot_q;
  assign bus.hazard_stall      = hazardStall;
  assign bus.hazard_count      = count_q;

endmodule
